// File: rtl/cook_timer_ctrl_pkg.sv
// Shared types and BCD limits for the microwave cook-time controller.
package cook_timer_pkg;

    localparam int         BCD_W        = 4;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/cook_timer_ctrl_bcd_digit_down.sv
// One BCD digit of the cook-time display: clear, shift-load and a decrement
// that wraps 0 -> MAX and reports the wrap as a borrow to the next digit.
module bcd_digit_down import cook_timer_pkg::*; #(
    parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec_en) begin
            value <= (value == '0) ? MAX : value - 4'd1;
        end
    end

    assign borrow_out = dec_en && (value == '0);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: MM:SS keypad entry, 1 Hz countdown, pause/resume.
// Optional done beeper is built only when COOK_TIMER_BEEP_EN is defined.
module cook_timer_ctrl import cook_timer_pkg::*; #(
    parameter int MAX_DIGITS = 4,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       magnetron_on,
    output logic       done,
    output logic       beep,
    output logic [2:0] dbg_state
);

    state_t     state, state_nxt;
    logic [2:0] key_cnt, key_cnt_nxt;
    logic       door_q;
    logic       shift_en, dec_en, clr_digits;
    logic       so_borrow, st_borrow, mo_borrow;

    // key_valid is a one-cycle strobe with no back-pressure: a key that the
    // current state cannot accept is simply dropped.
    logic digit_ok, cnt_full, upper_zero, time_zero, last_sec;
    assign digit_ok   = key_valid && (key_digit <= DIGIT_MAX);
    assign cnt_full   = (key_cnt == MAX_DIGITS[2:0]);
    assign upper_zero = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0);
    assign time_zero  = upper_zero && (sec_ones == '0);
    assign last_sec   = upper_zero && (sec_ones == 4'd1);

    always_comb begin
        state_nxt   = state;
        key_cnt_nxt = key_cnt;
        shift_en    = 1'b0;
        dec_en      = 1'b0;
        clr_digits  = 1'b0;
        case (state)
            IDLE, ENTRY: begin
                if (stop_clear) begin
                    state_nxt   = IDLE;
                    clr_digits  = 1'b1;
                    key_cnt_nxt = '0;
                end else if (state == ENTRY && start) begin
                    if (door_closed && !time_zero) state_nxt = COOKING;
                end else if (digit_ok && !cnt_full) begin
                    shift_en    = 1'b1;
                    key_cnt_nxt = key_cnt + 3'd1;
                    state_nxt   = ENTRY;
                end
            end
            COOKING: begin
                if (stop_clear || !door_closed) begin
                    state_nxt = PAUSED;
                end else if (tick_1hz) begin
                    dec_en = 1'b1;
                    if (last_sec) state_nxt = DONE;
                end
            end
            PAUSED: begin
                if (stop_clear) begin
                    state_nxt   = IDLE;
                    clr_digits  = 1'b1;
                    key_cnt_nxt = '0;
                end else if (start && door_closed) begin
                    state_nxt = COOKING;
                end
            end
            DONE: begin
                if (stop_clear || key_valid || (door_q && !door_closed)) begin
                    state_nxt   = IDLE;
                    clr_digits  = 1'b1;
                    key_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_digits  = 1'b1;
                key_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            key_cnt      <= '0;
            door_q       <= 1'b0;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            key_cnt      <= key_cnt_nxt;
            door_q       <= door_closed;
            magnetron_on <= (state_nxt == COOKING);
            done         <= (state_nxt == DONE);
        end
    end

    assign dbg_state = state;

    // Digits shift left on entry and borrow right-to-left on countdown.
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clock(clock), .reset(reset), .clear(clr_digits), .load(shift_en),
        .load_val(key_digit), .dec_en(dec_en), .value(sec_ones), .borrow_out(so_borrow)
    );
    bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock(clock), .reset(reset), .clear(clr_digits), .load(shift_en),
        .load_val(sec_ones), .dec_en(so_borrow), .value(sec_tens), .borrow_out(st_borrow)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
        .clock(clock), .reset(reset), .clear(clr_digits), .load(shift_en),
        .load_val(sec_tens), .dec_en(st_borrow), .value(min_ones), .borrow_out(mo_borrow)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
        .clock(clock), .reset(reset), .clear(clr_digits), .load(shift_en),
        .load_val(min_ones), .dec_en(mo_borrow), .value(min_tens), .borrow_out()
    );

`ifdef COOK_TIMER_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);
    logic [BW-1:0] beep_left;
    logic          beep_q;

    // Ticks are counted only after DONE is entered; the tick that finished
    // the countdown does not shorten the beep.
    always_ff @(posedge clock) begin
        if (reset || state_nxt != DONE) begin
            beep_left <= '0;
            beep_q    <= 1'b0;
        end else if (state != DONE) begin
            beep_left <= BEEP_TICKS[BW-1:0];
            beep_q    <= 1'b1;
        end else if (tick_1hz && beep_left != '0) begin
            beep_left <= beep_left - BW'(1);
            if (beep_left == BW'(1)) beep_q <= 1'b0;
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl: scenario tasks push expected
// display/status words and compare them with the words sampled after each cycle.
module tb_cook_timer_ctrl;
  import cook_timer_pkg::*;

  localparam int W = 22;
`ifdef COOK_TIMER_BEEP_EN
  localparam logic BP = 1'b1;
`else
  localparam logic BP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       magnetron_on, done, beep;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int compared = 0;
  int mismatched = 0;

  cook_timer_ctrl #(.MAX_DIGITS(4), .BEEP_TICKS(3)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
    .door_closed(door_closed), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .magnetron_on(magnetron_on),
    .done(done), .beep(beep), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;

  function automatic logic [W-1:0] mk(input logic [15:0] t, input logic mag,
                                      input logic dn, input logic bp, input state_t s);
    return {t, mag, dn, bp, s};
  endfunction

  // driver tasks: one clock cycle per call, outputs sampled 1 time unit after the edge
  task automatic apply(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sc, input logic tk);
    key_valid = kv; key_digit = kd; start = st; stop_clear = sc; tick_1hz = tk;
    @(posedge clock); #1;
    key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0; tick_1hz = 1'b0;
    got_q.push_back({min_tens, min_ones, sec_tens, sec_ones,
                     magnetron_on, done, beep, dbg_state});
  endtask

  task automatic press(input logic [3:0] d); apply(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic go();    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic stp();   apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic tck();   apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask
  task automatic hold();  apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask

  task automatic test_reset();
    logic [W-1:0] e, g;
    int n = 0;
    reset = 1'b1;
    apply(1'b1, 4'd5, 1'b1, 1'b0, 1'b1); exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    reset = 1'b0;
    hold();                              exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL reset[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_basic_count();
    logic [W-1:0] e, g;
    int n = 0;
    press(4'd1); exp_q.push_back(mk(16'h0001, 0, 0, 0, ENTRY));
    press(4'd3); exp_q.push_back(mk(16'h0013, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0130, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0130, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0129, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0128, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0127, 1, 0, 0, COOKING));
    stp();       exp_q.push_back(mk(16'h0127, 0, 0, 0, PAUSED));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL basic_count[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_done();
    logic [W-1:0] e, g;
    int n = 0;
    press(4'd0); exp_q.push_back(mk(16'h0000, 0, 0, 0, ENTRY));
    press(4'd2); exp_q.push_back(mk(16'h0002, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0002, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0001, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, BP, DONE));
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, BP, DONE));
    go();        exp_q.push_back(mk(16'h0000, 0, 1, BP, DONE));
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, BP, DONE));
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, 0, DONE));
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, 0, DONE));
    press(4'd5); exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'd5); exp_q.push_back(mk(16'h0005, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0005, 1, 0, 0, COOKING));
    for (int k = 4; k >= 1; k--) begin
      tck();     exp_q.push_back(mk(16'(k), 1, 0, 0, COOKING));
    end
    tck();       exp_q.push_back(mk(16'h0000, 0, 1, BP, DONE));
    door_closed = 1'b0;
    hold();      exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    door_closed = 1'b1;
    hold();      exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL done[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_borrow_pause();
    logic [W-1:0] e, g;
    int n = 0;
    press(4'd1); exp_q.push_back(mk(16'h0001, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0010, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0100, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0100, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0059, 1, 0, 0, COOKING));
    door_closed = 1'b0;
    tck();       exp_q.push_back(mk(16'h0059, 0, 0, 0, PAUSED));
    tck();       exp_q.push_back(mk(16'h0059, 0, 0, 0, PAUSED));
    go();        exp_q.push_back(mk(16'h0059, 0, 0, 0, PAUSED));
    door_closed = 1'b1;
    tck();       exp_q.push_back(mk(16'h0059, 0, 0, 0, PAUSED));
    press(4'd7); exp_q.push_back(mk(16'h0059, 0, 0, 0, PAUSED));
    go();        exp_q.push_back(mk(16'h0059, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0058, 1, 0, 0, COOKING));
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
                 exp_q.push_back(mk(16'h0058, 0, 0, 0, PAUSED));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'd1); exp_q.push_back(mk(16'h0001, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0010, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0100, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h1000, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h1000, 1, 0, 0, COOKING));
    tck();       exp_q.push_back(mk(16'h0959, 1, 0, 0, COOKING));
    stp();       exp_q.push_back(mk(16'h0959, 0, 0, 0, PAUSED));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL borrow_pause[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_entry_limits();
    logic [W-1:0] e, g;
    logic [15:0]  t;
    logic [3:0]   d;
    int n = 0;
    press(4'd1); exp_q.push_back(mk(16'h0001, 0, 0, 0, ENTRY));
    press(4'd2); exp_q.push_back(mk(16'h0012, 0, 0, 0, ENTRY));
    press(4'd3); exp_q.push_back(mk(16'h0123, 0, 0, 0, ENTRY));
    press(4'd4); exp_q.push_back(mk(16'h1234, 0, 0, 0, ENTRY));
    press(4'd5); exp_q.push_back(mk(16'h1234, 0, 0, 0, ENTRY));
    press(4'hC); exp_q.push_back(mk(16'h1234, 0, 0, 0, ENTRY));
    tck();       exp_q.push_back(mk(16'h1234, 0, 0, 0, ENTRY));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'hF); exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    t = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = 4'($urandom_range(0, 9));
      t = {t[11:0], d};
      press(d);  exp_q.push_back(mk(t, 0, 0, 0, ENTRY));
    end
    door_closed = 1'b0;
    go();        exp_q.push_back(mk(t, 0, 0, 0, ENTRY));
    door_closed = 1'b1;
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL entry_limits[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_start_stop_clash();
    logic [W-1:0] e, g;
    int n = 0;
    press(4'd7); exp_q.push_back(mk(16'h0007, 0, 0, 0, ENTRY));
    apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
                 exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'd9); exp_q.push_back(mk(16'h0009, 0, 0, 0, ENTRY));
    apply(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
                 exp_q.push_back(mk(16'h0009, 1, 0, 0, COOKING));
    stp();       exp_q.push_back(mk(16'h0009, 0, 0, 0, PAUSED));
    apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
                 exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'd0); exp_q.push_back(mk(16'h0000, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0000, 0, 0, 0, ENTRY));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    press(4'd9); exp_q.push_back(mk(16'h0009, 0, 0, 0, ENTRY));
    press(4'd9); exp_q.push_back(mk(16'h0099, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0099, 1, 0, 0, COOKING));
    for (int k = 8; k >= 0; k--) begin
      tck();     exp_q.push_back(mk({8'h00, 4'h9, 4'(k)}, 1, 0, 0, COOKING));
    end
    tck();       exp_q.push_back(mk(16'h0089, 1, 0, 0, COOKING));
    stp();       exp_q.push_back(mk(16'h0089, 0, 0, 0, PAUSED));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL start_stop_clash[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid_cook();
    logic [W-1:0] e, g;
    int n = 0;
    press(4'd5); exp_q.push_back(mk(16'h0005, 0, 0, 0, ENTRY));
    press(4'd1); exp_q.push_back(mk(16'h0051, 0, 0, 0, ENTRY));
    press(4'd0); exp_q.push_back(mk(16'h0510, 0, 0, 0, ENTRY));
    go();        exp_q.push_back(mk(16'h0510, 1, 0, 0, COOKING));
    reset = 1'b1;
    apply(1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
                 exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    reset = 1'b0;
    press(4'd3); exp_q.push_back(mk(16'h0003, 0, 0, 0, ENTRY));
    press(4'd4); exp_q.push_back(mk(16'h0034, 0, 0, 0, ENTRY));
    stp();       exp_q.push_back(mk(16'h0000, 0, 0, 0, IDLE));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL reset_mid_cook[%0d]: got %h expected %h", n, g, e); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_done();
    test_borrow_pause();
    test_entry_limits();
    test_start_stop_clash();
    test_reset_mid_cook();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
Microwave cook-time controller. Sits directly downstream of the keypad digit source, upstream of the display driver and magnetron relay. Loads up to four BCD digits (MM:SS), counts down once per 1 Hz tick while the door is closed, and stops at 00:00 without wrapping (non-recycling). Drives magnetron enable and a done indication.

Parameters:
MAX_DIGITS, 4, number of keypad digits accepted per entry (fixed at 4 for MM:SS; other values unsupported).
BEEP_TICKS, 3, tick count the done beeper stays on (used only with COOK_TIMER_BEEP_EN).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
tick_1hz  input  1  one-clock enable pulse, once per second
key_valid  input  1  one-clock strobe; key_digit is valid
key_digit  input  4  BCD digit 0-9; values 10-15 ignored
start  input  1  one-clock start/resume strobe
stop_clear  input  1  one-clock strobe: pause if cooking, else clear
door_closed  input  1  level; 1 = door shut
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens
magnetron_on  output  1  high only in COOKING
done  output  1  high in DONE state
beep  output  1  done beeper (0 when feature compiled out)

Behaviour:
- Reset: all digits 0, state IDLE, magnetron_on=0, done=0, beep=0. Reset dominates every other input in the same cycle.
- States: IDLE, ENTRY, COOKING, PAUSED, DONE. All outputs registered; 1-cycle latency from a strobe to the output change.
- IDLE/ENTRY, key_valid with digit <=9: shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit); go to ENTRY. A fifth digit is ignored (digit count saturates at 4). Digits >9 are ignored with no state change.
- ENTRY + start + door_closed + time != 0 -> COOKING. start with time==0 or door open: ignored.
- COOKING, tick_1hz: BCD decrement. sec_ones 0->9 borrows from sec_tens. sec_tens 0->5 borrows from min_ones. min_ones 0->9 borrows from min_tens. Entered sec_tens >5 (e.g. 0:99) counts down normally until the first borrow.
- Reaching 00:00 on a tick -> DONE in that same clock edge. Never decrements below 00:00.
- COOKING, door_closed=0 or stop_clear -> PAUSED; magnetron_on drops the next cycle. Any tick in that same cycle is not applied.
- PAUSED: start + door_closed -> COOKING. stop_clear -> IDLE with digits cleared. key_valid ignored.
- DONE: digits stay 00:00. start ignored. stop_clear, key_valid or door opening (door_closed 1->0) -> IDLE with digits cleared. A key_valid that exits DONE is discarded, not loaded.
- ENTRY, stop_clear -> IDLE, digits cleared, digit count 0.
- Simultaneous start+stop_clear: stop_clear wins. Simultaneous key_valid+start in ENTRY: start wins, key dropped.
- tick_1hz is ignored outside COOKING.

Optional Feature:
Macro COOK_TIMER_BEEP_EN. When defined: on entry to DONE, beep=1 for BEEP_TICKS tick_1hz pulses, then 0. Leaving DONE clears beep immediately. When undefined: beep is tied to 0 and the beep counter is not built.

Decomposition:
- Package cook_timer_pkg: state enum (IDLE, ENTRY, COOKING, PAUSED, DONE), BCD width constant (4), digit limits (SEC_TENS_MAX=5, DIGIT_MAX=9).
- Sub-module bcd_digit_down: one BCD digit with load/shift, decrement-enable and a MAX parameter. Outputs borrow_out when it wraps from 0. Four instances are chained by borrow; the top level holds the FSM and the zero detect.

Test Plan:
- Reset, then keys 1,3,0 and start with door closed; 3 ticks -> display 01:27, magnetron_on=1.
- Load 0:02, start, 2 ticks -> 00:00, done=1, magnetron_on=0. A further tick keeps 00:00.
- Load 1:00, start, 1 tick -> 00:59 (borrow across minutes). Door opens -> PAUSED, ticks ignored. Door closes, start -> resumes at 00:59.
- Keys 1,2,3,4,5 -> 12:34 (fifth digit ignored). Key 4'hC -> no change. stop_clear -> 00:00, IDLE.
- Assert start and stop_clear in the same cycle while in ENTRY -> IDLE, digits cleared. Assert reset mid-COOKING at 05:10 -> all outputs 0 next cycle.
- With COOK_TIMER_BEEP_EN defined and BEEP_TICKS=3: reach DONE -> beep high for exactly 3 ticks, then low. Without the macro, beep stays 0 throughout.
